// File: rtl/uart_receiver_param.sv
// Parametrised UART receiver: 2-flop input synchroniser, start-bit glitch
// rejection, optional even/odd parity, 1 or 2 stop bits, parity/framing flags.
module uart_receiver_param #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_in,
  output logic [DATA_BITS-1:0] byte_out,
  output logic                 ready_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
  localparam int unsigned STP_W = 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [STP_W-1:0] STP_LAST = STP_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic                 bit_s;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [STP_W-1:0]     stp_q, stp_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 ready_q, ready_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 par_x;
  logic                 ferr_now;

  assign bit_s = sync2_q;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: all decisions are taken at bit-centre sample points
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!bit_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) state_d = bit_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST && idx_q == IDX_LAST)
          state_d = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: begin
        if (cnt_q == CNT_LAST) state_d = S_STOP;
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST && stp_q == STP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values driven by the current state
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stp_d      = stp_q;
    sh_d       = sh_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    byte_d     = byte_q;
    ready_d    = 1'b0;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    par_x      = (^sh_q) ^ bit_s;
    ferr_now   = ferr_q | ~bit_s;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        stp_d = '0;
        if (!bit_s) begin
          perr_d = 1'b0;
          ferr_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          sh_d  = {bit_s, sh_q[DATA_BITS-1:1]};
          idx_d = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PAR: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          perr_d = (PARITY == 2) ? ~par_x : par_x;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          stp_d  = stp_q + 1'b1;
          ferr_d = ferr_now;
          if (stp_q == STP_LAST) begin
            byte_d     = sh_q;
            perr_out_d = (PARITY == 0) ? 1'b0 : perr_q;
            ferr_out_d = ferr_now;
            ready_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Synchroniser, counters, shift register and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      cnt_q      <= '0;
      idx_q      <= '0;
      stp_q      <= '0;
      sh_q       <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      byte_q     <= '0;
      ready_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
    end else begin
      sync1_q    <= bit_in;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stp_q      <= stp_d;
      sh_q       <= sh_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      byte_q     <= byte_d;
      ready_q    <= ready_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
    end
  end

  assign byte_out   = byte_q;
  assign ready_out  = ready_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign busy       = (state_q != S_IDLE);

endmodule
